// File: rtl/dm_access_responder.sv
// Data-memory responder: one load/store in flight, stalls the core meanwhile.
// Optional access counters are enabled with `define DM_ACCESS_STATS_EN.
module dm_access_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_access_valid,
  input  logic [31:0] cpu_dm_addr,
  input  logic        cpu_r_en_n,
  input  logic        cpu_w_en_n,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_lane_n,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall
`ifdef DM_ACCESS_STATS_EN
  ,
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_wr_cnt,
  output logic [15:0] stat_oor_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [31:0]       r_mem [DEPTH];
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_oor;
  logic              r_rd;
  logic              r_wr;
  logic [31:0]       r_wdata;
  logic              r_byte;
  logic [1:0]        r_sel;

  logic              w_accept;
  logic              w_fire;
  logic              w_do_wr;
  logic              w_do_rd;
  logic              w_oor_in;
  logic              w_byte_in;
  logic [1:0]        w_sel_in;
  logic [31:0]       w_word;
  logic [7:0]        w_byte_val;
  logic [31:0]       w_rd_fmt;

  assign w_accept = (r_state == S_IDLE) && cpu_access_valid;
  assign w_fire   = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_do_wr  = w_fire && r_wr && !r_oor && !rst;
  assign w_do_rd  = w_fire && r_rd && !r_wr;
  assign w_oor_in = |cpu_dm_addr[31:ADDR_W+2];

  // Stall as soon as a request appears in IDLE and through BUSY.
  assign cpu_stall = (r_state == S_BUSY) ||
                     ((r_state == S_IDLE) && cpu_access_valid);

  // Exactly one cleared lane bit selects a byte access; else full word.
  always_comb begin
    w_byte_in = 1'b1;
    w_sel_in  = 2'd0;
    case (cpu_lane_n)
      4'b1110: w_sel_in = 2'd0;
      4'b1101: w_sel_in = 2'd1;
      4'b1011: w_sel_in = 2'd2;
      4'b0111: w_sel_in = 2'd3;
      default: w_byte_in = 1'b0;
    endcase
  end

  // Format load data: whole word or sign-extended lane byte.
  always_comb begin
    w_word     = r_mem[r_idx];
    w_byte_val = w_word[{r_sel, 3'b000} +: 8];
    w_rd_fmt   = w_word;
    if (r_oor)
      w_rd_fmt = 32'd0;
    else if (r_byte)
      w_rd_fmt = {{24{w_byte_val[7]}}, w_byte_val};
  end

  // Control FSM, request latch and load-result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_oor     <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_wdata   <= 32'd0;
      r_byte    <= 1'b0;
      r_sel     <= 2'd0;
      cpu_rdata <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx   <= cpu_dm_addr[ADDR_W+1:2];
            r_oor   <= w_oor_in;
            r_rd    <= !cpu_r_en_n;
            r_wr    <= !cpu_w_en_n;
            r_wdata <= cpu_wdata;
            r_byte  <= w_byte_in;
            r_sel   <= w_sel_in;
            r_cnt   <= CNT_LOAD;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (w_do_rd)
              cpu_rdata <= w_rd_fmt;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      if (r_byte)
        r_mem[r_idx][{r_sel, 3'b000} +: 8] <= r_wdata[7:0];
      else
        r_mem[r_idx] <= r_wdata;
    end
  end

`ifdef DM_ACCESS_STATS_EN
  // Completion counters for reads, writes and out-of-range accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_cnt  <= 32'd0;
      stat_wr_cnt  <= 32'd0;
      stat_oor_cnt <= 16'd0;
    end else if (w_fire) begin
      if (r_wr)
        stat_wr_cnt <= stat_wr_cnt + 32'd1;
      else if (r_rd)
        stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (r_oor && (r_rd || r_wr))
        stat_oor_cnt <= stat_oor_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_access_responder.sv
// Randomized bench for dm_access_responder against a word-array model.
// Build with +define+DM_ACCESS_STATS_EN to also check the counters.
module tb_dm_access_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_access_valid;
  logic [31:0] cpu_dm_addr;
  logic        cpu_r_en_n;
  logic        cpu_w_en_n;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_lane_n;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
`ifdef DM_ACCESS_STATS_EN
  logic [31:0] stat_rd_cnt;
  logic [31:0] stat_wr_cnt;
  logic [15:0] stat_oor_cnt;
`endif

  always #5 clk = ~clk;

  dm_access_responder #(
    .DEPTH(1024), .ADDR_W(10), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_access_valid(cpu_access_valid),
    .cpu_dm_addr(cpu_dm_addr),
    .cpu_r_en_n(cpu_r_en_n),
    .cpu_w_en_n(cpu_w_en_n),
    .cpu_wdata(cpu_wdata),
    .cpu_lane_n(cpu_lane_n),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall)
`ifdef DM_ACCESS_STATS_EN
    ,
    .stat_rd_cnt(stat_rd_cnt),
    .stat_wr_cnt(stat_wr_cnt),
    .stat_oor_cnt(stat_oor_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_mem [64];
  logic [31:0] m_rdata;
  int          m_rd;
  int          m_wr;
  int          m_oor;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rdata = 32'd0;
    m_rd = 0;
    m_wr = 0;
    m_oor = 0;
  endtask

  task automatic model(input logic [31:0] a, input logic rn,
                       input logic wn, input logic [31:0] wd,
                       input logic [3:0] ln);
    bit          oor;
    int          zeros;
    int          pos;
    logic [31:0] w;
    logic [7:0]  b;
    oor = (a[31:12] != 20'd0);
    zeros = 0;
    pos = 0;
    for (int i = 0; i < 4; i++)
      if (!ln[i]) begin
        zeros++;
        pos = i;
      end
    if (!wn) begin
      m_wr++;
      if (oor)
        m_oor++;
      else if (zeros == 1)
        m_mem[a[7:2]][pos*8 +: 8] = wd[7:0];
      else
        m_mem[a[7:2]] = wd;
    end else if (!rn) begin
      m_rd++;
      if (oor) begin
        m_oor++;
        m_rdata = 32'd0;
      end else begin
        w = m_mem[a[7:2]];
        if (zeros == 1) begin
          b = w[pos*8 +: 8];
          m_rdata = {{24{b[7]}}, b};
        end else begin
          m_rdata = w;
        end
      end
    end
  endtask

  task automatic chk_stats();
`ifdef DM_ACCESS_STATS_EN
    chk("stat_rd", stat_rd_cnt, m_rd);
    chk("stat_wr", stat_wr_cnt, m_wr);
    chk("stat_oor", {16'd0, stat_oor_cnt}, m_oor);
`endif
  endtask

  // Called and returns at posedge+1; leaves the DUT back in IDLE.
  task automatic access(input logic [31:0] a, input logic rn,
                        input logic wn, input logic [31:0] wd,
                        input logic [3:0] ln, input bit hold);
    int cyc;
    cyc = 0;
    cpu_access_valid = 1'b1;
    cpu_dm_addr = a;
    cpu_r_en_n = rn;
    cpu_w_en_n = wn;
    cpu_wdata = wd;
    cpu_lane_n = ln;
    #1;
    chk("stall_req", {31'd0, cpu_stall}, 32'd1);
    while (cpu_stall === 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("stall_len", cyc, LAT + 1);
    model(a, rn, wn, wd, ln);
    chk("rdata", cpu_rdata, m_rdata);
    chk_stats();
    if (!hold)
      cpu_access_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  ln;
    logic        rn;
    logic        wn;
    bit          hold;
    rst = 1'b1;
    cpu_access_valid = 1'b0;
    cpu_dm_addr = 32'd0;
    cpu_r_en_n = 1'b1;
    cpu_w_en_n = 1'b1;
    cpu_wdata = 32'd0;
    cpu_lane_n = 4'hF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk_stats();

    // Reset mid-BUSY abandons an in-flight write.
    access(32'h10, 1'b1, 1'b0, 32'h1111_2222, 4'h0, 1'b0);
    access(32'h10, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    cpu_access_valid = 1'b1;
    cpu_dm_addr = 32'h10;
    cpu_r_en_n = 1'b1;
    cpu_w_en_n = 1'b0;
    cpu_wdata = 32'hDEAD_BEEF;
    cpu_lane_n = 4'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_access_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("abort_stall", {31'd0, cpu_stall}, 32'd0);
    chk("abort_rdata", cpu_rdata, 32'd0);
    repeat (LAT + 2) @(posedge clk);
    #1;
    access(32'h10, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    chk("abort_keep", cpu_rdata, 32'h1111_2222);

    // Out-of-range write then read.
    access(32'h0001_0000, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'h0, 1'b0);
    access(32'h0001_0000, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    chk("oor_rdata", cpu_rdata, 32'h0);

    // Fill the model-tracked window.
    for (int i = 0; i < 64; i++)
      access(i * 4, 1'b1, 1'b0, $urandom, 4'h0, 1'b0);

    // Word store/load, byte store, byte loads.
    access(32'h40, 1'b1, 1'b0, 32'h1234_5678, 4'h0, 1'b0);
    access(32'h40, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    chk("word_ld", cpu_rdata, 32'h1234_5678);
    access(32'h40, 1'b1, 1'b0, 32'h0000_00AB, 4'b1011, 1'b0);
    access(32'h40, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    chk("byte_st", cpu_rdata, 32'h12AB_5678);
    access(32'h40, 1'b0, 1'b1, 32'h0, 4'b1011, 1'b0);
    chk("lb_lane2", cpu_rdata, 32'hFFFF_FFAB);
    access(32'h40, 1'b0, 1'b1, 32'h0, 4'b1110, 1'b0);
    chk("lb_lane0", cpu_rdata, 32'h0000_0078);

    // Valid held across DONE, then a new write right after.
    access(32'h40, 1'b0, 1'b1, 32'h0, 4'h0, 1'b1);
    access(32'h44, 1'b1, 1'b0, 32'hCAFE_F00D, 4'h0, 1'b0);
    access(32'h44, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    chk("b2b_wr", cpu_rdata, 32'hCAFE_F00D);

    // Random mix including both/neither enables and odd lane masks.
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0)
        a = {$urandom_range(1, 32'hFFFFF), 12'($urandom)};
      else
        a = {24'd0, 6'($urandom), 2'($urandom)};
      case ($urandom_range(0, 5))
        0: ln = 4'b1110;
        1: ln = 4'b1101;
        2: ln = 4'b1011;
        3: ln = 4'b0111;
        4: ln = 4'b0000;
        default: ln = 4'($urandom);
      endcase
      rn = 1'($urandom);
      wn = 1'($urandom);
      hold = (k != 199) && ($urandom_range(0, 3) == 0);
      access(a, rn, wn, $urandom, ln, hold);
    end

    // Read back the whole window.
    for (int i = 0; i < 64; i++) begin
      access(i * 4, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
      chk("final_rd", cpu_rdata, m_mem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_access_responder.md
Name: dm_access_responder

Overview:
- Data-memory responder at the far end of the core's data-memory request interface.
- Accepts one load/store request at a time from the MEM stage and holds the core stalled while the access is in flight.
- Performs word or byte-lane access on an internal word array and returns load data already formatted for direct write-back.
- Sits beside the core in the SoC top, in place of the bare DM array.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- ADDR_W, 10, log2(DEPTH); word index = cpu_dm_addr[ADDR_W+1:2].
- LATENCY, 2, cycles from request acceptance to completion; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cpu_access_valid  input  1  MEM stage holds a valid load/store this cycle.
- cpu_dm_addr  input  32  byte address.
- cpu_r_en_n  input  1  active-low read request.
- cpu_w_en_n  input  1  active-low write request.
- cpu_wdata  input  32  store data, unshifted rt value.
- cpu_lane_n  input  4  active-low byte-lane mask; 4'b0000 means a full-word access; one zero bit means a byte access on that lane.
- cpu_rdata  output  32  load result.
- cpu_stall  output  1  stalls the PC and pipeline while the access is pending.

Behaviour:
- Reset (rst=1 at a clock edge): state returns to IDLE, counter clears, cpu_rdata=0, cpu_stall=0. Array contents are not cleared. A pending write is discarded. Any request in flight is abandoned with no write and no rdata update.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If cpu_access_valid=1, cpu_stall=1 combinationally in the same cycle.
  - On that edge, latch addr, r/w, wdata and lane; load counter=LATENCY-1; go to BUSY.
  - If valid=0, cpu_stall=0.
- BUSY:
  - cpu_stall=1.
  - While counter!=0, decrement.
  - At counter==0, perform the access at that edge and go to DONE.
  - With LATENCY=1, the access happens on the edge leaving BUSY after a single BUSY cycle.
- DONE:
  - cpu_stall=0 for exactly one cycle, so the core advances.
  - cpu_access_valid is ignored in DONE, because the same request is still visible.
  - Next state is IDLE.
  - Request-to-release: stall is high for LATENCY+1 cycles and low in the DONE cycle.
- Write, full word: array[idx] <= wdata.
- Write, byte: only the lane k with lane_n[k]=0 is written, with wdata[7:0]. Other lanes are unchanged.
- Read, full word: cpu_rdata <= array[idx].
- Read, byte: cpu_rdata <= sign-extended byte of lane k, i.e. {{24{b[7]}}, b}.
- Lane mask with more than one zero bit: treated as a full-word access.
- Read and write both asserted in a request: the write wins and cpu_rdata is unchanged.
- Neither read nor write asserted while valid=1: complete normally with no array or rdata change.
- cpu_rdata holds its value until the next read completes.
- Out-of-range address (cpu_dm_addr[31:ADDR_W+2] != 0): writes are dropped; reads return 0.
- Address bits [1:0] are ignored for word index. The lane mask alone selects the byte.

Optional Feature:
- Macro: DM_ACCESS_STATS_EN.
- When defined, add outputs stat_rd_cnt[31:0], stat_wr_cnt[31:0] and stat_oor_cnt[15:0].
  - Each increments by one on the completing edge of a read, a write, or an out-of-range access respectively.
  - Counters wrap on overflow and clear on rst.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset check: assert rst mid-BUSY during a write of 0xDEADBEEF to 0x10 -> next cycle cpu_stall=0 and cpu_rdata=0; a later word read of 0x10 returns the pre-test value, showing the write was discarded.
- Word store/load: LATENCY=2. Write 0x12345678 to 0x40 with lane_n=0000, then read 0x40 -> cpu_rdata=0x12345678. Stall is high 3 cycles per access and low in DONE.
- Byte store: word 0x40 holds 0x12345678. Store wdata=0x000000AB with lane_n=1011 (lane 2) -> word reads 0x12AB5678.
- Byte load sign-extension: lb lane 2 of 0x12AB5678 (lane_n=1011) -> 0xFFFFFFAB. lb lane 0 (lane_n=1110) -> 0x00000078.
- Back-to-back: valid held high across DONE for a read, then a new write is presented the cycle after DONE -> exactly one access per request, with no duplicate on the DONE cycle.
- Out-of-range: write 0xFFFF_FFFF to 0x0001_0000 (DEPTH=1024) then read it -> cpu_rdata=0. With DM_ACCESS_STATS_EN, stat_oor_cnt=2.
